// File: rtl/logic_reduce_stream_pkg.sv
// Shared op encoding and the per-bit base function for logic_reduce_stream.
package logic_reduce_stream_pkg;

    // op[1:0] selects the base function; op[OP_INV_BIT] inverts the final packet result
    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;
    localparam int         OP_INV_BIT = 2;

    // Single-bit base function; PASS forwards x
    function automatic logic base_op(input logic x, input logic y, input logic [1:0] sel);
        logic r;
        case (sel)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_reduce_stream_op_unit.sv
// Combinational WIDTH-bit bitwise op: z = inv ^ f(x, y, sel), applied per bit.
module logic_op_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       sel,
    input  logic             inv,
    output logic [WIDTH-1:0] z
);
    import logic_reduce_stream_pkg::*;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign z[i] = inv ^ base_op(x[i], y[i], sel);
    end

endmodule

// File: rtl/logic_reduce_stream.sv
// Packet-wide AND/OR/XOR/PASS reduction over a valid/ready stream.
// One registered result per packet, with a saturating beat count.
module logic_reduce_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_beats
);
    import logic_reduce_stream_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_hold;
    logic             in_packet;

    logic [2:0]       op_eff;
    logic [WIDTH-1:0] beat_v;
    logic [WIDTH-1:0] fold_v;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             beat_acc;
    logic             out_acc;

    // A pending result blocks new beats unless it is being taken this cycle
    assign in_ready = !out_valid || out_ready;
    assign beat_acc = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;

    // The first beat of a packet uses in_op directly; later beats use the held op
    assign op_eff = in_packet ? op_hold : in_op;

    // Beat stage: v = f(a, b); never inverted per beat
    logic_op_unit #(.WIDTH(WIDTH)) u_beat (
        .x   (in_a),
        .y   (in_b),
        .sel (op_eff[1:0]),
        .inv (1'b0),
        .z   (beat_v)
    );

    // Fold stage: f(v, acc); v on the x side so PASS keeps the newest beat
    logic_op_unit #(.WIDTH(WIDTH)) u_fold (
        .x   (beat_v),
        .y   (acc),
        .sel (op_eff[1:0]),
        .inv (1'b0),
        .z   (fold_v)
    );

    // Next accumulator and saturating beat count for an accepted beat
    always_comb begin
        acc_next = in_packet ? fold_v : beat_v;
        if (!in_packet)
            cnt_next = CNT_W'(1);
        else if (cnt == CNT_MAX)
            cnt_next = cnt;
        else
            cnt_next = cnt + CNT_W'(1);
    end

    // Packet accumulation and output register; a last beat reloads the output
    // even while the previous result is being taken (zero-bubble)
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            op_hold   <= '0;
            in_packet <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
        end else begin
            if (out_acc)
                out_valid <= 1'b0;
            if (beat_acc) begin
                if (!in_packet)
                    op_hold <= in_op;
                if (in_last) begin
                    out_data  <= op_eff[OP_INV_BIT] ? ~acc_next : acc_next;
                    out_beats <= cnt_next;
                    out_valid <= 1'b1;
                    in_packet <= 1'b0;
                end else begin
                    acc       <= acc_next;
                    cnt       <= cnt_next;
                    in_packet <= 1'b1;
                end
            end
        end
    end

endmodule
